mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage load/store sequencer sitting directly upstream of the byte-addressed DataMemory.
//  Accepts one request per valid/ready handshake, checks alignment, and drives registered
//  memory controls that stay stable for exactly one access cycle.
//  Captures load data and presents the result to the MEM/WB boundary with a valid/ready handshake.
// PARAMETERS
//  ADDR_W   9   byte-address width; matches the 512-byte DataMemory
//  DATA_W   32  data width
//  TAG_W    4   destination-register tag width carried through to writeback
// PORTS
//  clk          in   1       single clock; all state updates on the rising edge
//  reset        in   1       synchronous, active-high
//  req_valid    in   1       request present
//  req_ready    out  1       controller can accept; high only in IDLE
//  req_rw       in   1       1 = store, 0 = load
//  req_size     in   2       00 byte, 01 halfword, 10 word, 11 word
//  req_se       in   1       sign-extend load result
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   DATA_W  store data
//  req_tag      in   TAG_W   destination tag
//  mem_enable   out  1       DataMemory Enable
//  mem_rw       out  1       DataMemory ReadWrite
//  mem_se       out  1       DataMemory SE
//  mem_size     out  2       DataMemory Size
//  mem_addr     out  ADDR_W  DataMemory Address
//  mem_wdata    out  DATA_W  DataMemory DataIn
//  mem_rdata    in   DATA_W  DataMemory DataOut; combinational, valid during ACCESS
//  wb_valid     out  1       result held for MEM/WB
//  wb_ready     in   1       MEM/WB consumes the result
//  wb_is_load   out  1       1 = wb_data/wb_tag are meaningful
//  wb_data      out  DATA_W  captured load data
//  wb_tag       out  TAG_W   tag of the completed request
//  fault        out  1       one-cycle pulse on a misaligned request
//  fault_addr   out  ADDR_W  offending address; held until the next fault
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready=1.
//   Applies in any state, including mid-ACCESS; an in-flight store is not rolled back.
//  FSM (states enumerated in the package):
//   IDLE   : req_ready=1. On req_valid, latch all req_* fields.
//            Misaligned -> FAULT; otherwise -> ACCESS.
//   ACCESS : exactly 1 cycle. mem_enable=1; mem_* driven from the latched fields.
//            On the cycle-ending edge, loads capture mem_rdata into wb_data. -> RESP.
//   RESP   : wb_valid=1; wb_is_load, wb_data and wb_tag held stable.
//            wb_ready=1 -> IDLE; otherwise remain in RESP, stalling upstream.
//   FAULT  : fault=1 for one cycle; no memory access; wb_valid stays 0. -> IDLE.
//  Misalignment rules:
//   size 01 with addr[0]!=0, or size 10/11 with addr[1:0]!=0. Byte accesses never fault.
//  Memory-facing outputs:
//   mem_enable is 0 in every state except ACCESS.
//   mem_addr, mem_wdata, mem_size, mem_rw and mem_se are registered and do not change
//    while mem_enable=1.
//   mem_rw=0 and mem_enable=0 outside ACCESS, so no spurious writes occur.
//  Latency:
//   Handshake edge N -> ACCESS in cycle N+1 -> wb_valid in cycle N+2.
//   Minimum 3 cycles per request.
//  Stores also complete through RESP with wb_is_load=0, so ordering remains visible to MEM/WB.
//  Data passes unmodified in both directions; extension and byte ordering are done in DataMemory.
// STRUCTURE
//  Shared package mem_pkg:
//   size encodings SZ_BYTE/SZ_HALF/SZ_WORD, FSM state enum, and the ADDR_W/DATA_W defaults.
//  Sub-module mem_align_chk (combinational): (size, addr[1:0]) -> misaligned.
//  Registers and FSM live in this module.
// TESTING
//  1. Store word 0xDEADBEEF @0x010 then load word @0x010 ->
//     exactly one mem_enable cycle per request; load gives wb_data=0xDEADBEEF at N+2.
//  2. Load byte @0x011 with SE=1 after storing byte 0x80 there ->
//     wb_data=0xFFFFFF80; with SE=0 -> 0x00000080.
//  3. Halfword load @0x013 ->
//     fault pulse 1 cycle, fault_addr=0x013, mem_enable never high, wb_valid stays 0.
//  4. wb_ready held 0 for 5 cycles in RESP ->
//     wb_valid and wb_data stable, req_ready=0; a new req_valid is ignored until the drain.
//  5. reset asserted during ACCESS of a store ->
//     next cycle IDLE, mem_enable=0, req_ready=1, wb_valid=0.
//  6. Back-to-back req_valid held high ->
//     new request accepted every 3 cycles; mem_addr unchanged while mem_enable=1.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the MEM-stage load/store sequencer.
//               Covers the access-size encodings, the controller state
//               encoding and the default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 4;

  // 2'b11 is treated as a word access everywhere.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_align_chk.sv
`default_nettype none
// ============================================================================
// Module      : mem_align_chk
// Description : Combinational alignment checker. Flags a halfword access on
//               an odd address, or a word access that is not 4-byte aligned.
//               Byte accesses are always aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_align_chk
  import mem_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  // Decode the access size against the two low address bits.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      default: misaligned = |addr_lo;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage load/store sequencer in front of a byte-addressed
//               DataMemory. Accepts one request per handshake, rejects
//               misaligned accesses with a fault pulse, performs a single
//               memory access cycle and hands the result to MEM/WB.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  // request side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  // DataMemory side
  output logic              mem_enable,
  output logic              mem_rw,
  output logic              mem_se,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // writeback side
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_is_load,
  output logic [DATA_W-1:0] wb_data,
  output logic [TAG_W-1:0]  wb_tag,
  // fault reporting
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr
);

  state_t state;
  state_t state_nxt;

  logic              misaligned;
  logic              accept;

  // Request fields captured at the handshake; they feed the memory bus
  // directly, so the bus cannot change during the access cycle.
  logic              lat_rw;
  logic [1:0]        lat_size;
  logic              lat_se;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [TAG_W-1:0]  lat_tag;

  mem_align_chk u_align_chk (
    .size       (req_size),
    .addr_lo    (req_addr[1:0]),
    .misaligned (misaligned)
  );

  assign mem_se    = lat_se;
  assign mem_size  = lat_size;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs; mem_rw is gated so a write can
  // only ever be seen together with mem_enable.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    mem_enable = 1'b0;
    mem_rw     = 1'b0;
    wb_valid   = 1'b0;
    fault      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = misaligned ? ST_FAULT : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_enable = 1'b1;
        mem_rw     = lat_rw;
        state_nxt  = ST_RESP;
      end
      ST_RESP: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FAULT: begin
        fault     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request fields on the handshake edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_rw    <= 1'b0;
      lat_size  <= '0;
      lat_se    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_tag   <= '0;
    end else if (accept) begin
      lat_rw    <= req_rw;
      lat_size  <= req_size;
      lat_se    <= req_se;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_tag   <= req_tag;
    end
  end

  // Record the offending address; it is kept until the next fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_addr <= '0;
    end else if (accept && misaligned) begin
      fault_addr <= req_addr;
    end
  end

  // Build the writeback record at the end of the access cycle. Store
  // completions leave the previous load data in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_is_load <= 1'b0;
      wb_data    <= '0;
      wb_tag     <= '0;
    end else if (state == ST_ACCESS) begin
      wb_is_load <= ~lat_rw;
      wb_tag     <= lat_tag;
      if (!lat_rw) begin
        wb_data <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench for mem_access_ctrl with a
//               big-endian byte-addressed DataMemory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [1:0]        req_size;
  logic              req_se;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic              mem_enable;
  logic              mem_rw;
  logic              mem_se;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid;
  logic              wb_ready;
  logic              wb_is_load;
  logic [DATA_W-1:0] wb_data;
  logic [TAG_W-1:0]  wb_tag;
  logic              fault;
  logic [ADDR_W-1:0] fault_addr;

  int checks = 0;
  int errors = 0;
  int en_count = 0;
  int exp_en = 0;
  int en_run_viol = 0;
  int rw_viol = 0;
  logic prev_en = 1'b0;

  logic [7:0] dmem [0:511];

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_size   (req_size),
    .req_se     (req_se),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_tag    (req_tag),
    .mem_enable (mem_enable),
    .mem_rw     (mem_rw),
    .mem_se     (mem_se),
    .mem_size   (mem_size),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_is_load (wb_is_load),
    .wb_data    (wb_data),
    .wb_tag     (wb_tag),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  always #5 clk = ~clk;

  // DataMemory model: combinational read, big-endian byte order.
  always_comb begin
    mem_rdata = '0;
    case (mem_size)
      2'b00: mem_rdata = mem_se ? {{24{dmem[mem_addr][7]}}, dmem[mem_addr]}
                                : {24'h0, dmem[mem_addr]};
      2'b01: mem_rdata = mem_se ? {{16{dmem[mem_addr][7]}}, dmem[mem_addr], dmem[mem_addr + 9'd1]}
                                : {16'h0, dmem[mem_addr], dmem[mem_addr + 9'd1]};
      default: mem_rdata = {dmem[mem_addr], dmem[mem_addr + 9'd1],
                            dmem[mem_addr + 9'd2], dmem[mem_addr + 9'd3]};
    endcase
  end

  // DataMemory model: write on the clock edge while enabled for a store.
  always @(posedge clk) begin
    if (mem_enable && mem_rw) begin
      case (mem_size)
        2'b00: dmem[mem_addr] <= mem_wdata[7:0];
        2'b01: begin
          dmem[mem_addr]        <= mem_wdata[15:8];
          dmem[mem_addr + 9'd1] <= mem_wdata[7:0];
        end
        default: begin
          dmem[mem_addr]        <= mem_wdata[31:24];
          dmem[mem_addr + 9'd1] <= mem_wdata[23:16];
          dmem[mem_addr + 9'd2] <= mem_wdata[15:8];
          dmem[mem_addr + 9'd3] <= mem_wdata[7:0];
        end
      endcase
    end
  end

  // Count access cycles and flag any enable lasting more than one cycle.
  always @(posedge clk) begin
    if (mem_enable) en_count++;
    if (mem_enable && prev_en) en_run_viol++;
    prev_en = mem_enable;
  end

  // A write strobe without enable would be a spurious write.
  always @(negedge clk) begin
    if (mem_rw && !mem_enable) rw_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic drive(input logic rw, input logic [1:0] size, input logic se,
                       input logic [8:0] addr, input logic [31:0] wdata, input logic [3:0] tag);
    req_rw    = rw;
    req_size  = size;
    req_se    = se;
    req_addr  = addr;
    req_wdata = wdata;
    req_tag   = tag;
    req_valid = 1'b1;
  endtask

  // Full aligned request with wb_ready held high.
  task automatic run_req(input logic rw, input logic [1:0] size, input logic se,
                         input logic [8:0] addr, input logic [31:0] wdata,
                         input logic [3:0] tag, input logic [31:0] exp_data, input string nm);
    wait_ready();
    drive(rw, size, se, addr, wdata, tag);
    exp_en++;
    @(negedge clk);
    req_valid = 1'b0;
    check({nm, "_en"},   {31'b0, mem_enable}, 32'd1);
    check({nm, "_addr"}, {23'b0, mem_addr}, {23'b0, addr});
    check({nm, "_rw"},   {31'b0, mem_rw}, {31'b0, rw});
    if (rw) check({nm, "_wdata"}, mem_wdata, wdata);
    @(negedge clk);
    check({nm, "_wbv"},  {31'b0, wb_valid}, 32'd1);
    check({nm, "_en0"},  {31'b0, mem_enable}, 32'd0);
    check({nm, "_isld"}, {31'b0, wb_is_load}, {31'b0, ~rw});
    check({nm, "_tag"},  {28'b0, wb_tag}, {28'b0, tag});
    if (!rw) check({nm, "_data"}, wb_data, exp_data);
    @(negedge clk);
  endtask

  // Misaligned request: one fault cycle, no access, no writeback.
  task automatic run_fault(input logic [1:0] size, input logic [8:0] addr, input string nm);
    wait_ready();
    drive(1'b0, size, 1'b0, addr, 32'h0, 4'h1);
    @(negedge clk);
    req_valid = 1'b0;
    check({nm, "_f1"},   {31'b0, fault}, 32'd1);
    check({nm, "_fa"},   {23'b0, fault_addr}, {23'b0, addr});
    check({nm, "_en"},   {31'b0, mem_enable}, 32'd0);
    check({nm, "_wbv"},  {31'b0, wb_valid}, 32'd0);
    check({nm, "_rdy0"}, {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check({nm, "_f0"},   {31'b0, fault}, 32'd0);
    check({nm, "_fah"},  {23'b0, fault_addr}, {23'b0, addr});
    check({nm, "_rdy1"}, {31'b0, req_ready}, 32'd1);
    check({nm, "_wbv2"}, {31'b0, wb_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) dmem[i] = 8'h00;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_size  = 2'b00;
    req_se    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_tag   = '0;
    wb_ready  = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_en",    {31'b0, mem_enable}, 32'd0);
    check("rst_wbv",   {31'b0, wb_valid}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_fa",    {23'b0, fault_addr}, 32'd0);
    check("rst_data",  wb_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Word store then word load.
    run_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 4'h3, 32'h0, "st_w");
    run_req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 4'h5, 32'hDEADBEEF, "ld_w");

    // Byte store of 0x80, then signed and unsigned byte loads.
    run_req(1'b1, 2'b00, 1'b0, 9'h011, 32'h00000080, 4'h2, 32'h0, "st_b");
    run_req(1'b0, 2'b00, 1'b1, 9'h011, 32'h0, 4'h6, 32'hFFFFFF80, "ld_bse");
    run_req(1'b0, 2'b00, 1'b0, 9'h011, 32'h0, 4'h6, 32'h00000080, "ld_bze");

    // Alignment boundaries.
    run_fault(2'b01, 9'h013, "flt_h");
    run_fault(2'b10, 9'h012, "flt_w");
    run_fault(2'b11, 9'h011, "flt_w3");
    run_req(1'b0, 2'b00, 1'b0, 9'h013, 32'h0, 4'h8, 32'h000000EF, "ld_b13");
    run_req(1'b0, 2'b01, 1'b1, 9'h012, 32'h0, 4'h8, 32'hFFFFBEEF, "ld_h12");

    // Writeback stall: result held, new request ignored until drained.
    wb_ready = 1'b0;
    wait_ready();
    drive(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 4'hA);
    exp_en++;
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 9'h020, 32'hCAFEF00D, 4'h7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_wbv",  {31'b0, wb_valid}, 32'd1);
      check("stall_data", wb_data, 32'hDE80BEEF);
      check("stall_tag",  {28'b0, wb_tag}, 32'hA);
      check("stall_rdy",  {31'b0, req_ready}, 32'd0);
      check("stall_en",   {31'b0, mem_enable}, 32'd0);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    check("drain_rdy", {31'b0, req_ready}, 32'd1);
    exp_en++;
    @(negedge clk);
    req_valid = 1'b0;
    check("pend_en",    {31'b0, mem_enable}, 32'd1);
    check("pend_addr",  {23'b0, mem_addr}, 32'h020);
    check("pend_wdata", mem_wdata, 32'hCAFEF00D);
    @(negedge clk);
    check("pend_isld",  {31'b0, wb_is_load}, 32'd0);
    check("pend_tag",   {28'b0, wb_tag}, 32'h7);
    @(negedge clk);

    // Reset in the middle of a store access.
    wait_ready();
    drive(1'b1, 2'b10, 1'b0, 9'h040, 32'h11223344, 4'h4);
    exp_en++;
    @(negedge clk);
    req_valid = 1'b0;
    check("rma_en1", {31'b0, mem_enable}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rma_en0", {31'b0, mem_enable}, 32'd0);
    check("rma_rdy", {31'b0, req_ready}, 32'd1);
    check("rma_wbv", {31'b0, wb_valid}, 32'd0);
    check("rma_rw",  {31'b0, mem_rw}, 32'd0);
    check("rma_fa",  {23'b0, fault_addr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back requests with req_valid held high; the store before the
    // reset has already landed in memory.
    begin
      int acc = 0;
      int last = -1;
      wait_ready();
      drive(1'b0, 2'b10, 1'b0, 9'h040, 32'h0, 4'h9);
      for (int cyc = 0; cyc < 20 && acc < 4; cyc++) begin
        if (req_ready) begin
          if (last >= 0) check("b2b_gap", cyc - last, 32'd3);
          last = cyc;
          acc++;
          exp_en++;
        end
        if (mem_enable) check("b2b_addr", {23'b0, mem_addr}, 32'h040);
        if (wb_valid) check("b2b_data", wb_data, 32'h11223344);
        @(negedge clk);
      end
      req_valid = 1'b0;
      check("b2b_acc", acc, 32'd4);
      @(negedge clk);
      check("b2b_last", wb_data, 32'h11223344);
      @(negedge clk);
    end

    check("en_count", en_count, exp_en);
    check("en_run",   en_run_viol, 32'd0);
    check("rw_spur",  rw_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
